// File: rtl/arb_pkg.sv
// Shared types, default parameters and vector helpers for the round-robin arbiter.
package arb_pkg;

  // Arbiter control state: no grant outstanding, or one port holds the grant.
  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_MAX_HOLD  = 4;

  // Widest request vector the helpers below can handle; callers zero-extend
  // their NUM_PORTS-wide vectors into this container.
  localparam int ARB_VEC_W = 64;
  typedef logic [ARB_VEC_W-1:0] arb_vec_t;

  // Rotate the low n bits of v right by amt (0 <= amt < n), so that bit amt
  // lands in bit 0. A fixed LSB-first search on the result then starts at amt.
  function automatic arb_vec_t rot_right(arb_vec_t v, int amt, int n);
    arb_vec_t r;
    int       src;
    r = '0;
    for (int i = 0; i < ARB_VEC_W; i++) begin
      if (i < n) begin
        src = i + amt;
        if (src >= n) src = src - n;
        r[i] = v[src];
      end
    end
    return r;
  endfunction

  // Inverse of rot_right: rotate the low n bits of v left by amt.
  function automatic arb_vec_t rot_left(arb_vec_t v, int amt, int n);
    arb_vec_t r;
    int       dst;
    r = '0;
    for (int i = 0; i < ARB_VEC_W; i++) begin
      if (i < n) begin
        dst = i + amt;
        if (dst >= n) dst = dst - n;
        r[dst] = v[i];
      end
    end
    return r;
  endfunction

  // Bit position of a one-hot vector restricted to its low n bits; 0 if empty.
  function automatic int onehot_to_idx(arb_vec_t v, int n);
    int r;
    r = 0;
    for (int i = 0; i < ARB_VEC_W; i++) begin
      if (i < n && v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_prio_arb.sv
// Combinational fixed-priority arbiter: picks the lowest-numbered request.
module fixed_prio_arb
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  // Isolate the lowest set bit: req & -req (two's complement).
  always_comb begin
    gnt_o = req_i & (~req_i + NUM_PORTS'(1));
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grants and an optional hold
// limit that forces rotation when a holder keeps the grant while others wait.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int MAX_HOLD  = DEF_MAX_HOLD,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] requests_i,
  input  logic [NUM_PORTS-1:0] mask_i,
  output logic [NUM_PORTS-1:0] grants_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 grant_valid_o
);

  // Hold counter counts 1..MAX_HOLD; keep at least one bit when preemption is off.
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grants_q, grants_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] search_vec;
  logic [NUM_PORTS-1:0] search_rot;
  logic [NUM_PORTS-1:0] win_rot;
  logic [NUM_PORTS-1:0] win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     win_ptr_next;
  logic                 win_valid;
  logic                 holder_req;
  logic                 hold_expired;

  // Candidate set: unmasked requesters other than the current holder. When
  // idle grants_q is zero, so the same search serves fresh arbitration,
  // re-arbitration after a release, and preemption.
  always_comb begin
    eligible   = requests_i & ~mask_i;
    search_vec = eligible & ~grants_q;
    search_rot = NUM_PORTS'(rot_right(arb_vec_t'(search_vec), int'(ptr_q), NUM_PORTS));
  end

  fixed_prio_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_fixed_prio_arb (
    .req_i (search_rot),
    .gnt_o (win_rot)
  );

  // Undo the rotation to get the winner in port order, plus its index and the
  // pointer value that puts the port after it at highest priority.
  always_comb begin
    win_oh       = NUM_PORTS'(rot_left(arb_vec_t'(win_rot), int'(ptr_q), NUM_PORTS));
    win_valid    = |search_vec;
    win_idx      = IDX_W'(onehot_to_idx(arb_vec_t'(win_oh), NUM_PORTS));
    win_ptr_next = (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
    holder_req   = |(requests_i & grants_q);
    hold_expired = (MAX_HOLD > 0) && (cnt_q >= CNT_W'(MAX_HOLD));
  end

  // Next-state logic: grant, keep, move or drop the grant.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    state_d  = state_q;
    grants_d = grants_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          state_d  = ARB_BUSY;
          grants_d = win_oh;
          idx_d    = win_idx;
          ptr_d    = win_ptr_next;
          cnt_d    = CNT_W'(1);
        end
      end

      ARB_BUSY: begin
        if (!holder_req || (hold_expired && win_valid)) begin
          // Holder released, or held too long while another port waits.
          if (win_valid) begin
            grants_d = win_oh;
            idx_d    = win_idx;
            ptr_d    = win_ptr_next;
            cnt_d    = CNT_W'(1);
          end else begin
            state_d  = ARB_IDLE;
            grants_d = '0;
            idx_d    = '0;
            cnt_d    = '0;
          end
        end else if ((MAX_HOLD > 0) && (cnt_q < CNT_W'(MAX_HOLD))) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = ARB_IDLE;
        grants_d = '0;
        idx_d    = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // State register; reset clears the grant immediately, even mid-grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      grants_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      grants_q <= grants_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs come straight from registers: no combinational input-to-output path.
  always_comb begin
    grants_o      = grants_q;
    grant_idx_o   = idx_q;
    grant_valid_o = (state_q == ARB_BUSY);
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus randomized
// traffic compared against an integer-level round-robin reference model.
module tb_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [N-1:0] requests_i;
  logic [N-1:0] mask_i;
  logic [N-1:0] grants_o;
  logic [1:0]   grant_idx_o;
  logic         grant_valid_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: holder port (-1 = none), highest-priority port, hold cycles.
  int m_holder;
  int m_ptr;
  int m_hold;

  rr_arbiter #(
    .NUM_PORTS (N),
    .MAX_HOLD  (MH)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .requests_i    (requests_i),
    .mask_i        (mask_i),
    .grants_o      (grants_o),
    .grant_idx_o   (grant_idx_o),
    .grant_valid_o (grant_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First eligible port at or after m_ptr (wrapping), skipping port excl.
  function automatic int m_search(input logic [N-1:0] elig, input int excl);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (p != excl && elig[p]) return p;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_hold   = 0;
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic m_update(input logic [N-1:0] req, input logic [N-1:0] mask);
    logic [N-1:0] elig;
    int w;
    elig = req & ~mask;
    w = -1;
    if (m_holder < 0) begin
      w = m_search(elig, -1);
    end else if (!req[m_holder]) begin
      w = m_search(elig, m_holder);
      if (w < 0) m_holder = -1;
    end else begin
      if (MH > 0 && m_hold >= MH) w = m_search(elig, m_holder);
      if (w < 0 && m_hold < MH) m_hold++;
    end
    if (w >= 0) begin
      m_holder = w;
      m_ptr    = (w + 1) % N;
      m_hold   = 1;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] mask);
    logic [N-1:0] exp_g;
    requests_i = req;
    mask_i     = mask;
    @(posedge clk_i);
    m_update(req, mask);
    #1;
    exp_g = (m_holder < 0) ? '0 : N'(1 << m_holder);
    check("grants", 32'(grants_o), 32'(exp_g));
    check("grant_idx", 32'(grant_idx_o), (m_holder < 0) ? 32'd0 : 32'(m_holder));
    check("grant_valid", 32'(grant_valid_o), (m_holder < 0) ? 32'd0 : 32'd1);
    check("onehot0", 32'($onehot0(grants_o)), 32'd1);
    check("valid_vs_or", 32'(grant_valid_o), 32'(|grants_o));
    check("idx_bit", 32'(grants_o[grant_idx_o]), 32'(grant_valid_o));
    if (grant_valid_o) check("req_at_edge", 32'(req[grant_idx_o]), 32'd1);
  endtask

  // Step and additionally compare against a hand-derived grant vector.
  task automatic step_exp(input logic [N-1:0] req, input logic [N-1:0] mask,
                          input logic [N-1:0] exp_g, input string tag);
    step(req, mask);
    check(tag, 32'(grants_o), 32'(exp_g));
  endtask

  // Assert reset mid-cycle, confirm outputs clear at once, release on a negedge.
  task automatic do_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_grants", 32'(grants_o), 32'd0);
    check("rst_idx", 32'(grant_idx_o), 32'd0);
    check("rst_valid", 32'(grant_valid_o), 32'd0);
    m_reset();
    requests_i = '0;
    mask_i     = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] mk;

    rst_ni     = 1'b0;
    requests_i = '0;
    mask_i     = '0;
    m_reset();
    @(negedge clk_i);
    check("init_grants", 32'(grants_o), 32'd0);
    check("init_valid", 32'(grant_valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // No requests: nothing granted.
    for (int i = 0; i < 5; i++) step_exp(4'b0000, 4'b0000, 4'b0000, "idle_zero");

    // Everyone requests; each holder drops right after its grant.
    do_reset();
    step_exp(4'b1111, 4'b0000, 4'b0001, "rr_seq0");
    step_exp(4'b1110, 4'b0000, 4'b0010, "rr_seq1");
    step_exp(4'b1100, 4'b0000, 4'b0100, "rr_seq2");
    step_exp(4'b1000, 4'b0000, 4'b1000, "rr_seq3");
    step_exp(4'b0001, 4'b0000, 4'b0001, "rr_seq4");

    // Two steady requesters alternate every MAX_HOLD cycles with no gap.
    do_reset();
    for (int c = 0; c < 4 * MH; c++)
      step_exp(4'b0101, 4'b0000, ((c / MH) % 2 == 1) ? 4'b0100 : 4'b0001, "hold_alt");

    // Lone requester is never preempted.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step_exp(4'b0001, 4'b0000, 4'b0001, "lone_hold");
      check("lone_idx", 32'(grant_idx_o), 32'd0);
    end

    // Masked port loses arbitration; masking the holder later does not revoke.
    do_reset();
    step_exp(4'b0011, 4'b0001, 4'b0010, "mask_win");
    check("mask_idx", 32'(grant_idx_o), 32'd1);
    step_exp(4'b0011, 4'b0010, 4'b0010, "mask_keep0");
    step_exp(4'b0011, 4'b0010, 4'b0010, "mask_keep1");

    // Reset mid-grant clears outputs and the pointer.
    do_reset();
    step_exp(4'b0100, 4'b0000, 4'b0100, "pre_rst");
    do_reset();
    step_exp(4'b1100, 4'b0000, 4'b0100, "post_rst");

    // Randomized traffic with sticky requests and occasional masking.
    do_reset();
    rq = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      mk = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      step(rq, mk);
      if (c == 200) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
